hazard_stall_controller: RTL
============================

# hazard_stall_controller

Pipeline sequencing controller for the 5-stage MIPS core. It detects read-after-write hazards between the instruction in decode and producers still in execute or memory, and inserts the required bubbles with a counter-driven stall FSM. It drives the PC write enable, the fetch/decode register write enable, the control-mux select and a decode flush for taken control transfers. It replaces the constant-1 tie-offs of `PCWrite`, `DecodeWrite` and `controlMuxSignal` at top level.

## Interface
Parameters:
- `STALL_CNT_W`, default 32: width of the saturating stall-cycle performance counter.

Ports:
- `Clk`  in  1  single clock; all state updates on the rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `RsDecode`  in  5  rs field of the instruction in decode (`[25:21]`).
- `RtDecode`  in  5  rt field of the instruction in decode (`[20:16]`).
- `UsesRs`  in  1  decode instruction reads rs (includes branches and `jr`).
- `UsesRt`  in  1  decode instruction reads rt (R-type, `sw`, `beq`/`bne`).
- `RdExecute`  in  5  destination register in execute.
- `RegWriteExecute`  in  1  execute-stage instruction writes the register file.
- `RdMemory`  in  5  destination register in memory.
- `RegWriteMemory`  in  1  memory-stage instruction writes the register file.
- `RedirectTaken`  in  1  decode resolves a redirect this cycle (PCSrc, Jump or Jr).
- `PCWrite`  out  1  PC register write enable.
- `DecodeWrite`  out  1  Fetch_To_Decode write enable.
- `ControlMuxSignal`  out  1  1 passes control; 0 injects a bubble (all control zero).
- `FlushDecode`  out  1  synchronous clear of Fetch_To_Decode; the integrator ORs it into that register's clear.
- `StallCycles`  out  `STALL_CNT_W`  saturating count of bubble cycles inserted.

## Operation
- The core has no forwarding path. The register file is write-first, so a producer in writeback never causes a hazard.
- Hazard match for stage S: `RegWriteS && RdS != 0 && ((UsesRs && RsDecode == RdS) || (UsesRt && RtDecode == RdS))`.
- **HzEx** is the execute match, which needs 2 bubbles. **HzMem** is the memory match, which needs 1 bubble. If both match, HzEx wins.
- FSM states are RUN and STALL. The 2-bit register `Remain` holds the bubbles still owed after the current cycle.
- **RUN, no hazard:**
  - `PCWrite = DecodeWrite = ControlMuxSignal = 1`.
  - `FlushDecode` follows Configuration.
- **RUN, HzEx:**
  - `PCWrite = DecodeWrite = ControlMuxSignal = 0` and `FlushDecode = 0`.
  - Next state is STALL with `Remain = 1`.
- **RUN, HzMem only:** same outputs as HzEx, but the FSM stays in RUN. Next cycle the producer is in writeback, so the hazard clears.
- **STALL:**
  - Outputs are held as in a hazard cycle. Hazard inputs and `RedirectTaken` are ignored.
  - `Remain` decrements each cycle. When it reaches 0, the FSM returns to RUN.
- A stall cycle suppresses any redirect, because `PCWrite = 0` holds the PC. The branch re-resolves with correct operands once the stall ends.
- `StallCycles` increments on every cycle with `ControlMuxSignal = 0` and saturates at all-ones.

## Timing
- Hazard detection and outputs are combinational from the inputs and the state, in the same cycle. The state and counter are registered.
- Bubbles per hazard: 2 cycles for HzEx, 1 cycle for HzMem.
- Reset asserted (asynchronous):
  - State = RUN, `Remain = 0`, `StallCycles = 0`.
  - Outputs are forced to `PCWrite = DecodeWrite = ControlMuxSignal = 1` and `FlushDecode = 0`, independent of the inputs.
- Reset asserted mid-STALL: the FSM returns to RUN immediately and the owed bubbles are discarded.
- A hazard and `RedirectTaken` in the same RUN cycle: the hazard wins and `FlushDecode = 0`.
- Back-to-back hazards: the RUN cycle after STALL re-evaluates normally and may start a new stall.

## Configuration
- `HAZARD_DELAY_SLOT_EN`
  - **Defined:** MIPS branch delay slot. `FlushDecode` is always 0, and the instruction fetched after a taken redirect executes.
  - **Undefined:** in RUN with no hazard, `FlushDecode = RedirectTaken`. The wrong-path fetch is cleared to a NOP on the next edge, a 1-cycle penalty. `StallCycles` does not count flushes.

## Test plan
- **Reset:** assert `Reset` with arbitrary inputs -> `PCWrite = DecodeWrite = ControlMuxSignal = 1`, `FlushDecode = 0`, `StallCycles = 0`.
- **Execute hazard:** `RegWriteExecute = 1`, `RdExecute = 8`, `UsesRs = 1`, `RsDecode = 8` -> 2 consecutive cycles with all enables 0. On the third cycle the enables are 1 and `StallCycles = 2`.
- **Memory hazard, register 0 and UsesRt:**
  - `RegWriteMemory = 1`, `RdMemory = 9`, `UsesRt = 1`, `RtDecode = 9` -> exactly 1 bubble.
  - Repeat with `RdMemory = 0` -> no stall.
  - Repeat with `UsesRt = 0` -> no stall.
- **Both stages match the same register:** EX and MEM both match register 5 -> 2 bubbles, not 3.
- **Redirect:** `RedirectTaken = 1` with no hazard -> `FlushDecode = 1` for 1 cycle (`HAZARD_DELAY_SLOT_EN` undefined), 0 when defined. Same cycle plus HzEx -> `FlushDecode = 0` and the stall proceeds.
- **Reset mid-stall and saturation:**
  - Assert `Reset` in the first STALL cycle -> enables return to 1 at once.
  - With `STALL_CNT_W = 2`, drive 5 bubbles -> `StallCycles` stops at 3.

Source files
------------

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller
// Decode-stage RAW hazard detector and bubble sequencer for the 5-stage MIPS core.
// There is no forwarding, so a producer in execute costs 2 bubbles and one in memory
// costs 1. Writeback producers are covered by the write-first register file.
//
// Build option: define HAZARD_DELAY_SLOT_EN for MIPS delay-slot semantics, where
// FlushDecode stays 0. When it is undefined, a taken redirect in a clean RUN cycle
// flushes the wrong-path fetch.
module hazard_stall_controller #(
   parameter int unsigned STALL_CNT_W = 32
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic [4:0]             RsDecode,
   input  logic [4:0]             RtDecode,
   input  logic                   UsesRs,
   input  logic                   UsesRt,
   input  logic [4:0]             RdExecute,
   input  logic                   RegWriteExecute,
   input  logic [4:0]             RdMemory,
   input  logic                   RegWriteMemory,
   input  logic                   RedirectTaken,
   output logic                   PCWrite,
   output logic                   DecodeWrite,
   output logic                   ControlMuxSignal,
   output logic                   FlushDecode,
   output logic [STALL_CNT_W-1:0] StallCycles
);

   typedef enum logic [0:0] {StRun, StStall} stateT;

   stateT                  stateQ, stateD;
   logic [1:0]             remainQ, remainD;  // bubbles still owed after this cycle
   logic [STALL_CNT_W-1:0] stallCntQ;

   logic hzEx;
   logic hzMem;
   logic bubble;
   logic flush;

   // A stage conflicts when it writes a nonzero register that decode actually reads.
   function automatic logic stageMatch(input logic       regWrite,
                                       input logic [4:0] rd,
                                       input logic       usesRs,
                                       input logic [4:0] rs,
                                       input logic       usesRt,
                                       input logic [4:0] rt);
      return regWrite && (rd != 5'd0) &&
             ((usesRs && (rs == rd)) || (usesRt && (rt == rd)));
   endfunction

   // Hazard detection against the execute and memory producers.
   always_comb begin
      hzEx  = stageMatch(RegWriteExecute, RdExecute, UsesRs, RsDecode, UsesRt, RtDecode);
      hzMem = stageMatch(RegWriteMemory, RdMemory, UsesRs, RsDecode, UsesRt, RtDecode);
   end

   // Stall FSM next state and bubble/flush decisions.
   always_comb begin
      stateD  = stateQ;
      remainD = remainQ;
      bubble  = 1'b0;
      flush   = 1'b0;
      unique case (stateQ)
         StRun: begin
            if (hzEx) begin
               // The first bubble is issued now and one more is owed.
               bubble  = 1'b1;
               stateD  = StStall;
               remainD = 2'd1;
            end else if (hzMem) begin
               // The producer reaches writeback next cycle, so one bubble suffices.
               bubble = 1'b1;
            end else begin
`ifdef HAZARD_DELAY_SLOT_EN
               flush = 1'b0;
`else
               flush = RedirectTaken;
`endif
            end
         end
         StStall: begin
            // Inputs and redirects are ignored; PCWrite=0 already holds the PC.
            bubble = 1'b1;
            if (remainQ > 2'd1) begin
               remainD = remainQ - 2'd1;
            end else begin
               remainD = 2'd0;
               stateD  = StRun;
            end
         end
         default: begin
            stateD  = StRun;
            remainD = 2'd0;
         end
      endcase
      // Reset forces the pipeline to run regardless of the inputs.
      if (Reset) begin
         bubble = 1'b0;
         flush  = 1'b0;
      end
   end

   // Output drive: one bubble decision gates all three enables together.
   always_comb begin
      PCWrite          = ~bubble;
      DecodeWrite      = ~bubble;
      ControlMuxSignal = ~bubble;
      FlushDecode      = flush;
      StallCycles      = stallCntQ;
   end

   // State register; an asynchronous reset discards any owed bubbles.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         stateQ  <= StRun;
         remainQ <= 2'd0;
      end else begin
         stateQ  <= stateD;
         remainQ <= remainD;
      end
   end

   // Saturating count of bubble cycles; flushes are not counted.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         stallCntQ <= '0;
      end else if (bubble && (stallCntQ != {STALL_CNT_W{1'b1}})) begin
         stallCntQ <= stallCntQ + STALL_CNT_W'(1);
      end
   end

endmodule
